// File: rtl/if_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// if_fetch_ctrl
//
// Single-outstanding instruction fetch controller. Issues one request on the
// fetch bus, buffers the returned instruction, presents it downstream and
// computes the next fetch address from the external mini-decoder results
// (JAL / JALR / branch). A late redirect from execute overrides everything.
//
// Optional feature (compile-time macro):
//   IF_BTFN_PRED_EN  - backward-taken / forward-not-taken branch prediction.
//                      Undefined: every branch is predicted not-taken.
//
// Ports
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   ifu_req_o/addr_o      fetch request and address
//   ifu_gnt_i             request accepted by the bus
//   ifu_rvalid_i/rdata_i  fetch response
//   mdec_instr_o          buffered instruction to the mini-decoder
//   mdec_jal_i/jalr_i/branch_i, mdec_jalr_rs1_idx_i, mdec_imm_i
//                         mini-decoder results for the buffered instruction
//   jalr_rs1_idx_o        JALR base register index (pass-through)
//   jalr_rs1_rdata_i      JALR base register value
//   jalr_rs1_busy_i       JALR base register has a pending write
//   if_valid_o/ready_i    downstream handshake
//   if_instr_o/pc_o       instruction and its address
//   if_pred_taken_o       control transfer predicted taken
//   ex_redirect_i/pc_i    redirect from execute
// ---------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

module if_fetch_ctrl #(
   parameter logic [`XLEN-1:0] RESET_PC = 32'h8000_0000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   // fetch bus
   output logic                    ifu_req_o,
   output logic [`XLEN-1:0]        ifu_addr_o,
   input  logic                    ifu_gnt_i,
   input  logic                    ifu_rvalid_i,
   input  logic [`INSTR_WIDTH-1:0] ifu_rdata_i,
   // mini-decoder
   output logic [`INSTR_WIDTH-1:0] mdec_instr_o,
   input  logic                    mdec_jal_i,
   input  logic                    mdec_jalr_i,
   input  logic                    mdec_branch_i,
   input  logic [4:0]              mdec_jalr_rs1_idx_i,
   input  logic [`XLEN-1:0]        mdec_imm_i,
   // JALR base register read
   output logic [4:0]              jalr_rs1_idx_o,
   input  logic [`XLEN-1:0]        jalr_rs1_rdata_i,
   input  logic                    jalr_rs1_busy_i,
   // downstream
   output logic                    if_valid_o,
   input  logic                    if_ready_i,
   output logic [`INSTR_WIDTH-1:0] if_instr_o,
   output logic [`XLEN-1:0]        if_pc_o,
   output logic                    if_pred_taken_o,
   // execute redirect
   input  logic                    ex_redirect_i,
   input  logic [`XLEN-1:0]        ex_redirect_pc_i
);

   typedef enum logic [1:0] {
      ST_REQ,
      ST_RSP,
      ST_HOLD,
      ST_FLUSH
   } state_t;

   state_t                  state;
   logic [`XLEN-1:0]        pc;
   logic [`INSTR_WIDTH-1:0] ibuf;

   logic                    in_hold;
   logic                    jalr_wait;
   logic                    br_pred;
   logic                    br_taken;
   logic                    ctl_taken;
   logic [`XLEN-1:0]        jalr_sum;
   logic [`XLEN-1:0]        next_pc;

   // ------------------------------------------------------------------------
   // Branch prediction
   // ------------------------------------------------------------------------
`ifdef IF_BTFN_PRED_EN
   // negative offset means a backward branch (loop closing) -> taken
   assign br_pred = mdec_imm_i[`XLEN-1];
`else
   assign br_pred = 1'b0;
`endif

   assign br_taken  = mdec_branch_i & br_pred;
   assign ctl_taken = mdec_jal_i | mdec_jalr_i | br_taken;

   // ------------------------------------------------------------------------
   // Next-pc selection
   // ------------------------------------------------------------------------
   assign jalr_sum = jalr_rs1_rdata_i + mdec_imm_i;

   always_comb begin
      next_pc = pc + `XLEN'(4);
      if (mdec_jal_i) begin
         next_pc = pc + mdec_imm_i;
      end else if (mdec_jalr_i) begin
         next_pc = {jalr_sum[`XLEN-1:1], 1'b0};
      end else if (br_taken) begin
         next_pc = pc + mdec_imm_i;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign in_hold = (state == ST_HOLD);

   // a JALR must not leave until its base register value is final
   assign jalr_wait = mdec_jalr_i & jalr_rs1_busy_i;

   // reset forces the fetch-bus view to the reset address while rst_n is
   // low, before the first edge has loaded the registers
   assign ifu_req_o       = ~rst_n | (state == ST_REQ);
   assign ifu_addr_o      = rst_n ? pc : RESET_PC;
   assign if_valid_o      = rst_n & in_hold & ~jalr_wait & ~ex_redirect_i;
   assign if_pred_taken_o = rst_n & in_hold & ctl_taken;

   assign if_instr_o      = ibuf;
   assign if_pc_o         = pc;
   assign mdec_instr_o    = ibuf;
   assign jalr_rs1_idx_o  = mdec_jalr_rs1_idx_i;

   // ------------------------------------------------------------------------
   // Fetch FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_REQ;
         pc    <= RESET_PC;
         ibuf  <= '0;
      end else begin
         case (state)
            ST_REQ: begin
               if (ex_redirect_i) begin
                  pc <= ex_redirect_pc_i;
                  // a request granted this cycle still owes a response
                  if (ifu_gnt_i) state <= ST_FLUSH;
               end else if (ifu_gnt_i) begin
                  state <= ST_RSP;
               end
            end
            ST_RSP: begin
               if (ex_redirect_i) begin
                  pc    <= ex_redirect_pc_i;
                  state <= ifu_rvalid_i ? ST_REQ : ST_FLUSH;
               end else if (ifu_rvalid_i) begin
                  ibuf  <= ifu_rdata_i;
                  state <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (ex_redirect_i) begin
                  pc    <= ex_redirect_pc_i;
                  state <= ST_REQ;
               end else if (if_valid_o && if_ready_i) begin
                  pc    <= next_pc;
                  state <= ST_REQ;
               end
            end
            ST_FLUSH: begin
               // waiting out a response that belongs to a stale address
               if (ex_redirect_i) pc <= ex_redirect_pc_i;
               if (ifu_rvalid_i)  state <= ST_REQ;
            end
            default: state <= ST_REQ;
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
module tb_if_fetch_ctrl;

   localparam logic [31:0] RST_PC = 32'h8000_0000;

`ifdef IF_BTFN_PRED_EN
   localparam logic [31:0] BR_TGT  = 32'h8000_0018;
   localparam logic        BR_PRED = 1'b1;
`else
   localparam logic [31:0] BR_TGT  = 32'h8000_0024;
   localparam logic        BR_PRED = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ifu_req_o;
   logic [31:0] ifu_addr_o;
   logic        ifu_gnt_i;
   logic        ifu_rvalid_i;
   logic [31:0] ifu_rdata_i;
   logic [31:0] mdec_instr_o;
   logic        mdec_jal_i;
   logic        mdec_jalr_i;
   logic        mdec_branch_i;
   logic [4:0]  mdec_jalr_rs1_idx_i;
   logic [31:0] mdec_imm_i;
   logic [4:0]  jalr_rs1_idx_o;
   logic [31:0] jalr_rs1_rdata_i;
   logic        jalr_rs1_busy_i;
   logic        if_valid_o;
   logic        if_ready_i;
   logic [31:0] if_instr_o;
   logic [31:0] if_pc_o;
   logic        if_pred_taken_o;
   logic        ex_redirect_i;
   logic [31:0] ex_redirect_pc_i;

   always #5 clk = ~clk;

   if_fetch_ctrl #(.RESET_PC(RST_PC)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .ifu_req_o           (ifu_req_o),
      .ifu_addr_o          (ifu_addr_o),
      .ifu_gnt_i           (ifu_gnt_i),
      .ifu_rvalid_i        (ifu_rvalid_i),
      .ifu_rdata_i         (ifu_rdata_i),
      .mdec_instr_o        (mdec_instr_o),
      .mdec_jal_i          (mdec_jal_i),
      .mdec_jalr_i         (mdec_jalr_i),
      .mdec_branch_i       (mdec_branch_i),
      .mdec_jalr_rs1_idx_i (mdec_jalr_rs1_idx_i),
      .mdec_imm_i          (mdec_imm_i),
      .jalr_rs1_idx_o      (jalr_rs1_idx_o),
      .jalr_rs1_rdata_i    (jalr_rs1_rdata_i),
      .jalr_rs1_busy_i     (jalr_rs1_busy_i),
      .if_valid_o          (if_valid_o),
      .if_ready_i          (if_ready_i),
      .if_instr_o          (if_instr_o),
      .if_pc_o             (if_pc_o),
      .if_pred_taken_o     (if_pred_taken_o),
      .ex_redirect_i       (ex_redirect_i),
      .ex_redirect_pc_i    (ex_redirect_pc_i)
   );

   // Bench instruction format: [31:30] kind (0 ALU, 1 JAL, 2 JALR, 3 BR),
   // [29:25] rs1, [7:0] index into imm_tab.
   logic [31:0] imm_tab [0:255];

   assign mdec_jal_i          = (mdec_instr_o[31:30] == 2'd1);
   assign mdec_jalr_i         = (mdec_instr_o[31:30] == 2'd2);
   assign mdec_branch_i       = (mdec_instr_o[31:30] == 2'd3);
   assign mdec_jalr_rs1_idx_i = mdec_instr_o[29:25];
   assign mdec_imm_i          = imm_tab[mdec_instr_o[7:0]];
   // x5 reads a bogus value while its write is pending
   assign jalr_rs1_rdata_i    = (jalr_rs1_idx_o == 5'd5) ?
                                (jalr_rs1_busy_i ? 32'h0BAD_0000 : 32'h0000_1235) : 32'h0;

   function automatic logic [31:0] mk(input logic [1:0] k, input logic [4:0] rs, input logic [7:0] idx);
      return {k, rs, 17'h0, idx};
   endfunction

   typedef struct {
      logic [31:0] addr;
      logic [1:0]  kind;
      logic [4:0]  rs1;
      logic [31:0] imm;
      int          busy;
      int          stall;
      logic        pred;
      int          hold;
   } row_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          busy;
      int          stall;
      int          gap;
   } fet_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        pred;
      int          hold;
   } hs_t;

   function automatic row_t r(input logic [31:0] a, input logic [1:0] k, input logic [4:0] rs,
                              input logic [31:0] im, input int b, input int s, input logic p, input int h);
      row_t x;
      x.addr = a; x.kind = k; x.rs1 = rs; x.imm = im;
      x.busy = b; x.stall = s; x.pred = p; x.hold = h;
      return x;
   endfunction

   row_t  rows [12];
   fet_t  fq[$];
   hs_t   hq[$];

   int    vec = 0;
   int    errs = 0;
   int    cyc = 0;
   int    last_grant = 0;
   int    hold_start = 0;
   bit    gnt_en = 0;
   bit    granted_last = 0;
   bit    pend = 0;
   int    pend_cnt = 0;
   int    rsp_lat = 0;
   logic [31:0] pend_data = '0;
   int    pend_busy = 0;
   int    pend_stall = 0;
   int    busy_cnt = 0;
   int    stall_cnt = 0;

   localparam logic [31:0] JUNK = {2'd2, 5'd5, 17'h0, 8'd200};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic push_fetch(input logic [31:0] a, input logic [31:0] d, input int b, input int s, input int g);
      fet_t f;
      f.addr = a; f.data = d; f.busy = b; f.stall = s; f.gap = g;
      fq.push_back(f);
   endtask

   task automatic push_hs(input logic [31:0] p, input logic [31:0] i, input logic pr, input int h);
      hs_t e;
      e.pc = p; e.instr = i; e.pred = pr; e.hold = h;
      hq.push_back(e);
   endtask

   // drive the next cycle's inputs just after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      ex_redirect_i    = 1'b0;
      ex_redirect_pc_i = '0;
      ifu_gnt_i        = gnt_en;
      if (ifu_rvalid_i) begin
         pend       = 0;
         busy_cnt   = pend_busy;
         stall_cnt  = pend_stall;
         hold_start = cyc;
      end
      if (granted_last) begin
         pend     = 1;
         pend_cnt = rsp_lat;
      end
      if (pend && pend_cnt == 0) begin
         ifu_rvalid_i = 1'b1;
         ifu_rdata_i  = pend_data;
      end else begin
         ifu_rvalid_i = 1'b0;
         if (pend) pend_cnt--;
      end
      jalr_rs1_busy_i = (busy_cnt > 0);
      if (busy_cnt > 0) busy_cnt--;
      if_ready_i = !(stall_cnt > 0);
      if (stall_cnt > 0) stall_cnt--;
   endtask

   // observe outputs mid-cycle and score bus grants and handshakes
   task automatic sample();
      fet_t f;
      hs_t  e;
      @(negedge clk);
      granted_last = 0;
      if (!rst_n) begin
         chk("rst_req", ifu_req_o, 1'b1);
         chk("rst_addr", ifu_addr_o, RST_PC);
         chk("rst_valid", if_valid_o, 1'b0);
         chk("rst_pred", if_pred_taken_o, 1'b0);
      end else begin
         if (ifu_req_o && ifu_gnt_i) begin
            granted_last = 1;
            if (fq.size() == 0) begin
               chk("unexpected_grant", ifu_addr_o, 32'hFFFF_FFFF);
            end else begin
               f = fq.pop_front();
               chk("fetch_addr", ifu_addr_o, f.addr);
               if (f.gap != 0) chk("fetch_gap", cyc - last_grant, f.gap);
               pend_data  = f.data;
               pend_busy  = f.busy;
               pend_stall = f.stall;
            end
            last_grant = cyc;
         end
         if (if_valid_o && if_ready_i) begin
            if (hq.size() == 0) begin
               chk("unexpected_handshake", if_pc_o, 32'hFFFF_FFFF);
            end else begin
               e = hq.pop_front();
               chk("hs_pc", if_pc_o, e.pc);
               chk("hs_instr", if_instr_o, e.instr);
               chk("hs_pred", if_pred_taken_o, e.pred);
               chk("hs_hold", cyc - hold_start + 1, e.hold);
            end
         end
      end
   endtask

   task automatic step();
      tick();
      sample();
   endtask

   task automatic run_until_empty(input int budget);
      int n = 0;
      while (hq.size() > 0 && n < budget) begin
         step();
         n++;
      end
      if (hq.size() > 0) chk("timeout_handshake", hq.size(), 0);
   endtask

   task automatic wait_grant(input int budget);
      int n = 0;
      do begin
         step();
         n++;
      end while (!granted_last && n < budget);
      if (!granted_last) chk("timeout_grant", 0, 1);
   endtask

   initial begin
      for (int unsigned i = 0; i < 256; i++) imm_tab[i] = '0;
      rst_n = 1'b0; ifu_gnt_i = 1'b0; ifu_rvalid_i = 1'b0; ifu_rdata_i = '0;
      jalr_rs1_busy_i = 1'b0; if_ready_i = 1'b1;
      ex_redirect_i = 1'b0; ex_redirect_pc_i = '0;

      //            addr          kind rs1 imm            busy stall pred     hold
      rows[0]  = r(32'h8000_0000, 2'd0, 0, 32'h0000_0040, 0, 0, 1'b0,    1);
      rows[1]  = r(32'h8000_0004, 2'd0, 0, 32'h0000_0040, 0, 0, 1'b0,    1);
      rows[2]  = r(32'h8000_0008, 2'd1, 0, 32'h0000_0008, 0, 0, 1'b1,    1);
      rows[3]  = r(32'h8000_0010, 2'd1, 0, 32'hFFFF_FFF0, 0, 0, 1'b1,    1);
      rows[4]  = r(32'h8000_0000, 2'd0, 5, 32'h0000_0040, 2, 0, 1'b0,    1);
      rows[5]  = r(32'h8000_0004, 2'd0, 0, 32'h0000_0040, 0, 2, 1'b0,    3);
      rows[6]  = r(32'h8000_0008, 2'd2, 5, 32'h0000_0004, 4, 0, 1'b1,    5);
      rows[7]  = r(32'h0000_1238, 2'd1, 0, 32'h7FFF_EDE8, 0, 0, 1'b1,    1);
      rows[8]  = r(32'h8000_0020, 2'd3, 0, 32'hFFFF_FFF8, 0, 0, BR_PRED, 1);
      rows[9]  = r(BR_TGT,        2'd3, 0, 32'h0000_0008, 0, 0, 1'b0,    1);
      rows[10] = r(BR_TGT + 4,    2'd2, 5, 32'h0000_0CCB, 0, 0, 1'b1,    1);
      rows[11] = r(32'h0000_1F00, 2'd0, 0, 32'h0000_0040, 0, 0, 1'b0,    1);

      for (int unsigned i = 0; i < 12; i++) begin
         logic [31:0] w;
         w = mk(rows[i].kind, rows[i].rs1, 8'(i + 1));
         imm_tab[i + 1] = rows[i].imm;
         push_fetch(rows[i].addr, w, rows[i].busy, rows[i].stall, (i == 0) ? 0 : rows[i-1].hold + 2);
         push_hs(rows[i].addr, w, rows[i].pred, rows[i].hold);
      end
      for (int unsigned i = 201; i < 205; i++) imm_tab[i] = 32'h0000_0040;
      imm_tab[200] = 32'h0000_0010;

      // reset, then the table-driven instruction stream
      for (int unsigned i = 0; i < 3; i++) step();
      gnt_en = 1;
      tick();
      rst_n = 1'b1;
      sample();
      run_until_empty(300);
      gnt_en = 0;

      // redirect while waiting for the response; response arrives in FLUSH
      rsp_lat = 2;
      push_fetch(32'h0000_1F04, JUNK, 0, 0, 0);
      gnt_en = 1;
      wait_grant(20);
      gnt_en = 0;
      tick();
      ex_redirect_i = 1'b1; ex_redirect_pc_i = 32'h8000_0100;
      sample();
      tick(); sample();
      chk("flush_req", ifu_req_o, 1'b0);
      chk("flush_addr", ifu_addr_o, 32'h8000_0100);
      tick(); sample();
      chk("flush_rvalid_req", ifu_req_o, 1'b0);
      chk("flush_rvalid_valid", if_valid_o, 1'b0);
      rsp_lat = 0;
      push_fetch(32'h8000_0100, mk(2'd0, 0, 8'd201), 0, 0, 0);
      push_hs(32'h8000_0100, mk(2'd0, 0, 8'd201), 1'b0, 1);
      gnt_en = 1;
      run_until_empty(20);
      gnt_en = 0;

      // redirect in REQ: first without grant, then together with a grant
      tick();
      ex_redirect_i = 1'b1; ex_redirect_pc_i = 32'h8000_0300;
      sample();
      chk("req_redir_nogrant_req", ifu_req_o, 1'b1);
      tick();
      push_fetch(32'h8000_0300, JUNK, 0, 0, 0);
      ifu_gnt_i = 1'b1;
      ex_redirect_i = 1'b1; ex_redirect_pc_i = 32'h8000_0200;
      sample();
      tick(); sample();
      chk("req_redir_grant_flush_req", ifu_req_o, 1'b0);
      tick(); sample();
      chk("req_redir_grant_req", ifu_req_o, 1'b1);
      chk("req_redir_grant_addr", ifu_addr_o, 32'h8000_0200);
      push_fetch(32'h8000_0200, mk(2'd0, 0, 8'd202), 0, 0, 0);
      push_hs(32'h8000_0200, mk(2'd0, 0, 8'd202), 1'b0, 1);
      gnt_en = 1;
      run_until_empty(20);
      gnt_en = 0;

      // redirect while holding a valid instruction
      push_fetch(32'h8000_0204, mk(2'd0, 0, 8'd203), 0, 0, 0);
      gnt_en = 1;
      wait_grant(20);
      gnt_en = 0;
      tick(); sample();
      tick();
      ex_redirect_i = 1'b1; ex_redirect_pc_i = 32'h8000_0400;
      sample();
      chk("hold_redir_valid", if_valid_o, 1'b0);
      tick(); sample();
      chk("hold_redir_req", ifu_req_o, 1'b1);
      chk("hold_redir_addr", ifu_addr_o, 32'h8000_0400);
      push_fetch(32'h8000_0400, mk(2'd0, 0, 8'd204), 0, 0, 0);
      push_hs(32'h8000_0400, mk(2'd0, 0, 8'd204), 1'b0, 1);
      gnt_en = 1;
      run_until_empty(20);
      gnt_en = 0;

      // reset while a response is outstanding; stale rvalid after release
      rsp_lat = 1;
      push_fetch(32'h8000_0404, JUNK, 0, 0, 0);
      gnt_en = 1;
      wait_grant(20);
      gnt_en = 0;
      tick();
      rst_n = 1'b0;
      sample();
      tick();
      rst_n = 1'b1;
      sample();
      chk("post_rst_stale_rvalid", ifu_rvalid_i, 1'b1);
      chk("post_rst_req", ifu_req_o, 1'b1);
      chk("post_rst_addr", ifu_addr_o, RST_PC);
      chk("post_rst_valid", if_valid_o, 1'b0);
      rsp_lat = 0;
      push_fetch(RST_PC, mk(2'd0, 0, 8'd201), 0, 0, 0);
      push_hs(RST_PC, mk(2'd0, 0, 8'd201), 1'b0, 1);
      gnt_en = 1;
      run_until_empty(20);
      gnt_en = 0;
      step();

      chk("fetch_queue_drained", fq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule

// File: doc/if_fetch_ctrl.md
IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000: first fetch address after reset.
REQ-002 SHALL have ports clk, input, 1: sole clock, rising-edge.
REQ-003 SHALL have ports rst_n, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have ports ifu_req_o out 1, ifu_addr_o out `XLEN, ifu_gnt_i in 1, ifu_rvalid_i in 1, ifu_rdata_i in `INSTR_WIDTH: fetch bus, at most one outstanding request.
REQ-005 SHALL have ports mdec_instr_o out `INSTR_WIDTH, mdec_jal_i, mdec_jalr_i, mdec_branch_i in 1, mdec_jalr_rs1_idx_i in 5, mdec_imm_i in `XLEN: mini-decoder hookup.
REQ-006 SHALL have ports jalr_rs1_idx_o out 5, jalr_rs1_rdata_i in `XLEN, jalr_rs1_busy_i in 1: JALR base read plus pending-write flag.
REQ-007 SHALL have ports if_valid_o out 1, if_ready_i in 1, if_instr_o out `INSTR_WIDTH, if_pc_o out `XLEN, if_pred_taken_o out 1: downstream handshake.
REQ-008 SHALL have ports ex_redirect_i in 1, ex_redirect_pc_i in `XLEN: late redirect from execute.

Function
REQ-009 SHALL implement FSM states REQ, RSP, HOLD, FLUSH; pc register, instruction buffer ibuf.
REQ-010 REQ: ifu_req_o=1, ifu_addr_o=pc; ifu_gnt_i=1 -> RSP; else stay.
REQ-011 RSP: ifu_rvalid_i=1 -> ibuf<=ifu_rdata_i, go HOLD; else stay.
REQ-012 HOLD: mdec_instr_o=if_instr_o=ibuf, if_pc_o=pc; mdec_instr_o=ibuf in all states.
REQ-013 HOLD: if_valid_o=1 unless (mdec_jalr_i & jalr_rs1_busy_i) or ex_redirect_i; if_valid_o=0 in other states.
REQ-014 jalr_rs1_idx_o SHALL equal mdec_jalr_rs1_idx_i combinationally.
REQ-015 next_pc: jal -> pc+imm; jalr -> (rs1_rdata+imm) with bit0 cleared; branch predicted taken -> pc+imm; otherwise pc+4; all sums modulo 2^`XLEN.
REQ-016 if_pred_taken_o=1 for jal, jalr, predicted-taken branch; 0 otherwise.
REQ-017 HOLD & if_valid_o & if_ready_i -> pc<=next_pc, go REQ (fetch-to-fetch minimum 3 cycles).
REQ-018 ex_redirect_i has priority over every other event; pc<=ex_redirect_pc_i same edge.
REQ-019 Redirect in REQ without grant -> stay REQ; in REQ with same-cycle grant -> FLUSH.
REQ-020 Redirect in RSP without rvalid -> FLUSH; with same-cycle rvalid -> data dropped, go REQ.
REQ-021 Redirect in HOLD -> ibuf discarded, go REQ, no downstream handshake that cycle.
REQ-022 FLUSH: ifu_req_o=0; ifu_rvalid_i=1 -> data dropped, go REQ; redirect in FLUSH updates pc, stays FLUSH unless rvalid same cycle.
REQ-023 ifu_rvalid_i outside RSP/FLUSH SHALL be ignored.

Reset
REQ-024 rst_n=0 at clk edge -> state REQ, pc=RESET_PC, ibuf=0; takes effect mid-transaction, outstanding response dropped by REQ-023.
REQ-025 During and after reset: ifu_req_o=1, ifu_addr_o=RESET_PC, if_valid_o=0, if_pred_taken_o=0.

Configuration
REQ-026 Macro IF_BTFN_PRED_EN defined: branch predicted taken iff mdec_imm_i[`XLEN-1]=1 (backward).
REQ-027 Macro IF_BTFN_PRED_EN undefined: every branch predicted not-taken (pc+4, if_pred_taken_o=0).

Verification
REQ-028 Reset release, gnt and rvalid immediate, ready=1, ADDI stream -> ifu_addr 8000_0000, 8000_0004, 8000_0008 every 3 cycles; pred_taken=0.
REQ-029 pc=8000_0010 holds JAL imm=-16 -> if_pred_taken_o=1, next ifu_addr 8000_0000.
REQ-030 JALR rs1=x5, busy=1 for 4 cycles then rs1_rdata=1235, imm=4 -> if_valid_o low 4 cycles, next ifu_addr 0000_1238.
REQ-031 Branch imm=-8 at 8000_0020 -> with IF_BTFN_PRED_EN next 8000_0018, pred_taken=1; without, 8000_0024, pred_taken=0.
REQ-032 Redirect to 8000_0100 in RSP, rvalid 2 cycles later -> FLUSH, response dropped, if_valid_o stays 0, next ifu_addr 8000_0100.
REQ-033 rst_n low in RSP, stale rvalid after release -> ignored; first delivered instruction from RESET_PC.
